// File: rtl/pe_pkg.sv
// Shared definitions for the integer compute-array processing elements.
//   pe_op_t        : 2-bit opcode carried with every operand beat
//   DWIDTH_DOUBLE  : default lane width for 64-bit elements
//   DWIDTH_INT     : default lane width for 32-bit elements
package pe_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_MAC = 2'd3
    } pe_op_t;

    localparam int unsigned DWIDTH_DOUBLE = 64;
    localparam int unsigned DWIDTH_INT    = 32;

endpackage

// File: rtl/pe_lane.sv
// One SIMD lane: stage-1 arithmetic (combinational) plus the lane's MAC accumulator.
//   clk, rst : clock, asynchronous active-low reset
//   en       : beat accepted this cycle (pipeline not stalled)
//   op, last : shared opcode and MAC final-term flag
//   a, b     : lane operands
//   result   : stage-1 result, registered by the top-level delay chain
module pe_lane
    import pe_pkg::*;
#(
    parameter int unsigned DWIDTH     = DWIDTH_DOUBLE,
    parameter int unsigned SIGNED_MUL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  pe_op_t            op,
    input  logic              last,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    output logic [DWIDTH-1:0] result
);

    localparam int unsigned HALF     = DWIDTH / 2;
    localparam bit          SIGN_EXT = (SIGNED_MUL != 0);

    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0] a_ext, b_ext, prod;

    always_comb begin
        // Extending the half-width operands to DWIDTH makes the truncated product exact
        // in both signed and unsigned modes.
        a_ext = {{HALF{SIGN_EXT & a[HALF-1]}}, a[HALF-1:0]};
        b_ext = {{HALF{SIGN_EXT & b[HALF-1]}}, b[HALF-1:0]};
        prod  = a_ext * b_ext;

        result = '0;
        unique case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_MUL: result = prod;
            OP_MAC: result = acc_q + prod;
            default: result = '0;
        endcase

        acc_d = acc_q;
        if (en && (op == OP_MAC)) begin
            acc_d = last ? '0 : result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pe_typeb.sv
// SIMD integer ALU processing element with a fixed-latency pipeline.
//   clk, rst            : clock, asynchronous active-low reset
//   in_valid / in_ready : operand beat handshake (in_ready drops only on output stall)
//   in_op, in_last      : shared opcode (ADD/SUB/MUL/MAC) and MAC final-term flag
//   in_a, in_b          : packed operands, lane i at [i*DWIDTH +: DWIDTH]
//   out_valid/out_ready : result beat handshake
//   out_data, out_last  : packed registered results and the beat's last flag
module pe_typeb
    import pe_pkg::*;
#(
    parameter int unsigned DWIDTH     = 64,
    parameter int unsigned LANES      = 1,
    parameter int unsigned LATENCY    = 6,
    parameter int unsigned SIGNED_MUL = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_op,
    input  logic                    in_last,
    input  logic [LANES*DWIDTH-1:0] in_a,
    input  logic [LANES*DWIDTH-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DWIDTH-1:0] out_data,
    output logic                    out_last
);

    localparam int unsigned W = LANES * DWIDTH;

    logic               stall;
    logic               accept;
    logic [W-1:0]       lane_res;
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] last_q;
    logic [W-1:0]       data_q [LATENCY];

    assign stall    = vld_q[LATENCY-1] && !out_ready;
    assign in_ready = !stall;
    // in_ready already excludes stall, so accept is the lane enable.
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_lane #(
            .DWIDTH     (DWIDTH),
            .SIGNED_MUL (SIGNED_MUL)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (accept),
            .op     (pe_op_t'(in_op)),
            .last   (in_last),
            .a      (in_a[i*DWIDTH +: DWIDTH]),
            .b      (in_b[i*DWIDTH +: DWIDTH]),
            .result (lane_res[i*DWIDTH +: DWIDTH])
        );
    end

    // Stage 1 captures the lane results; stages 2..LATENCY are a plain shift chain.
    // Bubbles shift through as zero data so idle outputs stay clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                data_q[s] <= '0;
            end
        end else if (!stall) begin
            vld_q     <= {vld_q[LATENCY-2:0], accept};
            last_q    <= {last_q[LATENCY-2:0], accept && in_last};
            data_q[0] <= accept ? lane_res : '0;
            for (int s = 1; s < LATENCY; s++) begin
                data_q[s] <= data_q[s-1];
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_last  = last_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule
